tcdm_bank_pm: RTL and testbench
===============================

TCDM_BANK_PM -- requirements
Module: tcdm_bank_pm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, word address width; bank depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_CUTS, default 2, physical cuts; a power of two, at most 2**(ADDR_WIDTH-1).
REQ-004 SHALL have parameter WAKE_CYCLES, default 4, wake-up settle delay in cycles; at least 1.
REQ-005 SHALL have one clock and an asynchronous active-high reset: CLK (in, 1, clock) and RST (in, 1, async reset, active high).
REQ-006 SHALL have these request-side ports:
- req_i (in, 1): access request.
- gnt_o (out, 1): request accepted this cycle.
- wen_i (in, 1): 1 = write, 0 = read.
- be_i (in, DATA_WIDTH/8): byte enables, active high.
- add_i (in, ADDR_WIDTH): word address.
- wdata_i (in, DATA_WIDTH): write data.
- rdata_o (out, DATA_WIDTH): read data.
- rvalid_o (out, 1): rdata_o valid.
REQ-007 SHALL have these power and control ports:
- sleep_req_i (in, 1): request standby.
- sleep_ack_o (out, 1): all cuts in standby.
- init_req_i (in, 1): request a zero-fill sweep.
- busy_o (out, 1): state is not ACTIVE.
- tm_i (in, 1): test mode, passed to every cut.

Function
REQ-008 SHALL implement FSM states INIT, ACTIVE, SLEEP, WAKE.
REQ-009 SHALL decode addresses as follows:
- Cut index = add_i[ADDR_WIDTH-1 -: log2(NUM_CUTS)].
- Cut-local address = the remaining low bits.
- Only the selected cut has CSN low; all others have CSN high.
REQ-010 SHALL derive each cut's active-low bit mask by replicating ~be_i[k] across byte k.
REQ-011 SHALL assert gnt_o = req_i only in ACTIVE, combinationally; gnt_o SHALL be 0 in every other state.
REQ-012 SHALL, for a granted read, assert rvalid_o exactly 1 cycle after grant, with rdata_o taken from the cut index registered at grant.
REQ-013 SHALL keep rvalid_o at 0 for writes; back-to-back reads SHALL give one rvalid_o per grant, in order.
REQ-014 SHALL hold rdata_o at its last value while rvalid_o is 0.
REQ-015 SHALL run INIT as follows:
- A counter sweeps cut-local addresses 0 .. 2**ADDR_WIDTH/NUM_CUTS-1.
- Each cycle it writes zero with all bytes enabled to all cuts in parallel.
- After the final address it goes to ACTIVE.
REQ-016 SHALL, in ACTIVE, act on sleep_req_i=1 only in a cycle with req_i=0; go to SLEEP the next cycle; request takes priority when both are high.
REQ-017 SHALL, in SLEEP, drive STDBY=1 and CSN=1 to all cuts, assert sleep_ack_o=1, and preserve contents.
REQ-018 SHALL leave SLEEP for WAKE when sleep_req_i=0, deasserting sleep_ack_o in that same transition cycle.
REQ-019 SHALL hold WAKE for exactly WAKE_CYCLES cycles, then enter ACTIVE.
REQ-020 SHALL, in ACTIVE with req_i=0 and sleep_req_i=0, enter INIT on init_req_i=1.
REQ-021 SHALL ignore init_req_i outside ACTIVE.
REQ-022 SHALL give sleep_req_i priority over init_req_i when both are high in the same cycle.
REQ-023 SHALL ignore sleep_req_i during INIT; it is sampled again once in ACTIVE.
REQ-024 SHALL assert busy_o=1 in INIT, SLEEP and WAKE.

Reset
REQ-025 SHALL, while RST=1, force: state INIT, sweep counter 0, gnt_o 0, rvalid_o 0, rdata_o 0, sleep_ack_o 0, busy_o 1, WAKE counter 0.
REQ-026 SHALL restart INIT from address 0 when RST is asserted mid-sweep or in any other state.
REQ-027 SHALL drop any in-flight rvalid_o when reset is asserted.

Configuration
REQ-028 SHALL support macro TCDM_BANK_OUT_REG_EN.
- Defined: adds an output register; read latency is 2 cycles (rvalid_o 2 cycles after grant); reset value of the register is 0.
- Undefined: read latency is 1 cycle per REQ-012.

Structure
REQ-029 SHALL place in package tcdm_bank_pkg: the FSM state enum, a cut-index width function (log2 of NUM_CUTS), and the byte-to-bitmask expansion function.
REQ-030 SHALL instantiate NUM_CUTS copies of sub-module tcdm_cut.
- Ports: CLK, CSN, WEN, WMN, A, D, Q, STDBY, TM.
- Behaviour: single-port, synchronous read, 1-cycle latency, bit-masked write.

Verification
REQ-031 Reset then idle -> busy_o=1 for 1024 cycles (defaults), then ACTIVE; a read of address 0x7FF returns 0x00000000 with rvalid_o 1 cycle after grant.
REQ-032 Write 0xDEADBEEF to 0x400 with be_i=4'b0101, then read 0x400 -> 0x00AD00EF, with cut 1 selected and cut 0 CSN high.
REQ-033 req_i and sleep_req_i together for 3 cycles with reads of 0x001..0x003 -> 3 grants and 3 rvalids, then SLEEP; drop sleep_req_i -> sleep_ack_o falls, ACTIVE exactly 4 cycles later, data intact.
REQ-034 Assert RST at sweep address 0x100 -> after release, INIT restarts at 0; ACTIVE after 1024 cycles.
REQ-035 Compile with TCDM_BANK_OUT_REG_EN and issue back-to-back reads of 0x010 and 0x011 -> rvalid_o at grant+2 and grant+3, in order.

Source files
------------

// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the power-managed TCDM bank.
package tcdm_bank_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKE   = 2'd3
  } state_e;

  function automatic int unsigned cut_idx_w(input int unsigned num_cuts);
    return $clog2(num_cuts);
  endfunction

  // Active-low write mask for one byte lane.
  function automatic logic [7:0] be_to_mask(input logic be);
    return {8{~be}};
  endfunction

endpackage

// File: rtl/tcdm_cut.sv
// Behavioural single-port SRAM cut: synchronous read, bit-masked write, standby input.
module tcdm_cut #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  CSN,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WMN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  STDBY,
  input  logic                  TM
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Test mode has no effect in this behavioural model.
  logic w_unused_tm;
  assign w_unused_tm = TM;

  always_ff @(posedge CLK) begin
    if (!CSN && !STDBY) begin
      if (!WEN) begin
        r_mem[A] <= (r_mem[A] & WMN) | (D & ~WMN);
      end else begin
        Q <= r_mem[A];
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_pm.sv
// Power-managed TCDM bank built from NUM_CUTS cuts, with zero-fill sweep and sleep/wake.
// Optional macro TCDM_BANK_OUT_REG_EN adds a read output register (2-cycle read latency).
module tcdm_bank_pm
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned NUM_CUTS    = 2,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  input  logic                    sleep_req_i,
  output logic                    sleep_ack_o,
  input  logic                    init_req_i,
  output logic                    busy_o,
  input  logic                    tm_i
);

  localparam int unsigned CIW  = cut_idx_w(NUM_CUTS);
  localparam int unsigned SELW = (CIW == 0) ? 1 : CIW;
  localparam int unsigned LAW  = ADDR_WIDTH - CIW;
  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned WCW  = $clog2(WAKE_CYCLES + 1);

  state_e                r_state, w_next;
  logic [LAW-1:0]        r_sweep;
  logic [WCW-1:0]        r_wake;
  logic [SELW-1:0]       w_cut, r_sel;
  logic                  r_rvalid;
  logic                  w_rd_gnt;

  logic [NUM_CUTS-1:0]   w_csn;
  logic                  w_wen;
  logic                  w_stdby;
  logic [DATA_WIDTH-1:0] w_wmn_req, w_wmn, w_d;
  logic [LAW-1:0]        w_a;
  logic [DATA_WIDTH-1:0] w_q [NUM_CUTS];
  logic [DATA_WIDTH-1:0] w_q_sel;

  if (CIW > 0) begin : gen_idx
    assign w_cut = add_i[ADDR_WIDTH-1 -: CIW];
  end else begin : gen_idx_single
    assign w_cut = '0;
  end

  always_comb begin
    w_wmn_req = '1;
    for (int unsigned k = 0; k < NB; k++) begin
      w_wmn_req[8*k +: 8] = be_to_mask(be_i[k]);
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a pending request always wins over sleep/init in ACTIVE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_INIT:   if (r_sweep == '1) w_next = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!req_i) begin
          if (sleep_req_i)     w_next = ST_SLEEP;
          else if (init_req_i) w_next = ST_INIT;
        end
      end
      ST_SLEEP:  if (!sleep_req_i) w_next = ST_WAKE;
      ST_WAKE:   if (r_wake == WCW'(WAKE_CYCLES - 1)) w_next = ST_ACTIVE;
      default:   w_next = ST_INIT;
    endcase
  end

  // Output logic: handshake, status and per-cut controls
  always_comb begin
    gnt_o       = 1'b0;
    busy_o      = 1'b1;
    sleep_ack_o = 1'b0;
    w_csn       = '1;
    w_wen       = 1'b1;
    w_wmn       = '1;
    w_a         = add_i[LAW-1:0];
    w_d         = wdata_i;
    w_stdby     = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_csn = '0;
        w_wen = 1'b0;
        w_wmn = '0;
        w_a   = r_sweep;
        w_d   = '0;
      end
      ST_ACTIVE: begin
        busy_o = 1'b0;
        gnt_o  = req_i;
        if (req_i) begin
          for (int unsigned c = 0; c < NUM_CUTS; c++) begin
            if (w_cut == SELW'(c)) w_csn[c] = 1'b0;
          end
          w_wen = ~wen_i;
          w_wmn = w_wmn_req;
        end
      end
      ST_SLEEP: begin
        w_stdby     = 1'b1;
        sleep_ack_o = sleep_req_i;
      end
      ST_WAKE: ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sweep <= '0;
      r_wake  <= '0;
    end else begin
      // The sweep counter spans exactly the cut depth, so it wraps to 0 as INIT ends.
      r_sweep <= (r_state == ST_INIT) ? r_sweep + 1'b1 : '0;
      r_wake  <= (r_state == ST_WAKE && w_next == ST_WAKE) ? r_wake + 1'b1 : '0;
    end
  end

  for (genvar g = 0; g < NUM_CUTS; g++) begin : gen_cut
    tcdm_cut #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (LAW)
    ) u_cut (
      .CLK   (CLK),
      .CSN   (w_csn[g]),
      .WEN   (w_wen),
      .WMN   (w_wmn),
      .A     (w_a),
      .D     (w_d),
      .Q     (w_q[g]),
      .STDBY (w_stdby),
      .TM    (tm_i)
    );
  end

  assign w_rd_gnt = gnt_o & ~wen_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rvalid <= 1'b0;
      r_sel    <= '0;
    end else begin
      r_rvalid <= w_rd_gnt;
      if (w_rd_gnt) r_sel <= w_cut;
    end
  end

  assign w_q_sel = w_q[r_sel];

`ifdef TCDM_BANK_OUT_REG_EN
  logic                  r_rvalid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rvalid_q <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      r_rvalid_q <= r_rvalid;
      if (r_rvalid) r_rdata_q <= w_q_sel;
    end
  end

  assign rvalid_o = r_rvalid_q;
  assign rdata_o  = r_rdata_q;
`else
  logic [DATA_WIDTH-1:0] r_hold;

  // Cut Q is only trusted in the valid cycle; the holding register covers every other cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold <= '0;
    end else if (r_rvalid) begin
      r_hold <= w_q_sel;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rvalid ? w_q_sel : r_hold;
`endif

endmodule

// File: tb/tb_tcdm_bank_pm.sv
// Directed bench for tcdm_bank_pm with a latency-aware read scoreboard.
module tb_tcdm_bank_pm;

`ifdef TCDM_BANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_i, gnt_o, wen_i;
  logic [3:0]  be_i;
  logic [10:0] add_i;
  logic [31:0] wdata_i, rdata_o;
  logic        rvalid_o, sleep_req_i, sleep_ack_o, init_req_i, busy_o, tm_i;

  tcdm_bank_pm dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .wen_i       (wen_i),
    .be_i        (be_i),
    .add_i       (add_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .sleep_req_i (sleep_req_i),
    .sleep_ack_o (sleep_ack_o),
    .init_req_i  (init_req_i),
    .busy_o      (busy_o),
    .tm_i        (tm_i)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2048];
  logic [31:0] exp_hold;
  int          cyc, checks, errors, n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rvalid", rvalid_o, 1);
      chk("rdata", rdata_o, sb[0].data);
      exp_hold = sb[0].data;
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", rvalid_o, 0);
      chk("rdata_hold", rdata_o, exp_hold);
    end
  endtask

  task automatic do_read(input logic [10:0] a);
    req_i = 1'b1; wen_i = 1'b0; add_i = a; be_i = 4'hF;
    #1;
    chk("gnt_rd", gnt_o, 1);
    sb.push_back('{model[a], cyc + LAT});
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    req_i = 1'b1; wen_i = 1'b1; add_i = a; be_i = be; wdata_i = d;
    #1;
    chk("gnt_wr", gnt_o, 1);
    for (int k = 0; k < 4; k++) if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic idle(input int cycles);
    req_i = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic wait_init(input int exp_len);
    n = 0;
    while (busy_o && n < 1500) begin
      tick();
      n++;
    end
    chk("init_len", n, exp_len);
    for (int i = 0; i < 2048; i++) model[i] = '0;
  endtask

  task automatic wait_wake();
    n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    chk("wake_len", n, 4);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; exp_hold = '0;
    RST = 1'b1; req_i = 1'b1; wen_i = 1'b0; be_i = 4'hF; add_i = '0; wdata_i = '0;
    sleep_req_i = 1'b1; init_req_i = 1'b0; tm_i = 1'b0;
    for (int i = 0; i < 2048; i++) model[i] = '0;

    // Reset state
    #2;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_ack", sleep_ack_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    repeat (3) tick();
    req_i = 1'b0; sleep_req_i = 1'b0;
    RST = 1'b0;
    wait_init(1024);

    // Zero-filled top address
    do_read(11'h7FF); tick(); idle(3);

    // Partial write, cut selection
    do_write(11'h400, 32'hDEADBEEF, 4'b0101);
    chk("csn_wr", dut.w_csn, 2'b01);
    tick();
    do_read(11'h400);
    chk("csn_rd", dut.w_csn, 2'b01);
    tick(); idle(3);

    do_write(11'h001, 32'h11111111, 4'hF); tick();
    do_write(11'h002, 32'hA5A5A5A5, 4'b1100); tick();
    do_write(11'h003, 32'h33333333, 4'hF); tick();
    do_write(11'h7FE, 32'hCAFEF00D, 4'hF); tick();
    do_write(11'h010, 32'h01010101, 4'hF); tick();
    do_write(11'h011, 32'h12345678, 4'b1110); tick();
    idle(1);

    // Requests take priority over sleep, then standby and wake
    sleep_req_i = 1'b1;
    do_read(11'h001); tick();
    do_read(11'h002); tick();
    do_read(11'h003); tick();
    req_i = 1'b0;
    tick();
    chk("sleep_ack", sleep_ack_o, 1);
    chk("sleep_busy", busy_o, 1);
    req_i = 1'b1; init_req_i = 1'b1;
    #1;
    chk("sleep_gnt", gnt_o, 0);
    tick(); tick();
    req_i = 1'b0; init_req_i = 1'b0;
    chk("sleep_ack_hold", sleep_ack_o, 1);
    sleep_req_i = 1'b0;
    #1;
    chk("ack_fall", sleep_ack_o, 0);
    tick();
    wait_wake();
    do_read(11'h001); tick();
    do_read(11'h002); tick();
    do_read(11'h003); tick();
    do_read(11'h400); tick();
    idle(3);

    // Back-to-back reads with a write in between
    do_read(11'h010); tick();
    do_read(11'h011); tick();
    do_write(11'h012, 32'h0BADF00D, 4'hF); tick();
    do_read(11'h7FE); tick();
    do_read(11'h012); tick();
    idle(3);

    // Request beats init; sleep beats init
    init_req_i = 1'b1;
    do_read(11'h011); tick();
    req_i = 1'b0; init_req_i = 1'b0;
    chk("req_over_init", busy_o, 0);
    idle(2);
    sleep_req_i = 1'b1; init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0;
    chk("sleep_over_init", sleep_ack_o, 1);
    sleep_req_i = 1'b0;
    tick();
    wait_wake();
    do_read(11'h7FE); tick(); idle(3);

    // Explicit init; sleep request ignored while sweeping
    init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0; sleep_req_i = 1'b1; req_i = 1'b1;
    repeat (5) begin
      chk("init_gnt", gnt_o, 0);
      chk("init_ack", sleep_ack_o, 0);
      tick();
    end
    sleep_req_i = 1'b0; req_i = 1'b0;
    wait_init(1019);
    do_read(11'h400); tick();
    do_read(11'h001); tick();
    idle(3);

    // Reset drops in-flight read and restarts the sweep
    do_write(11'h7FE, 32'h77777777, 4'hF); tick();
    do_read(11'h7FE); tick();
    RST = 1'b1;
    #1;
    chk("rst_drop_rvalid", rvalid_o, 0);
    chk("rst_drop_rdata", rdata_o, 0);
    chk("rst_drop_busy", busy_o, 1);
    sb.delete();
    exp_hold = '0;
    tick(); tick();
    RST = 1'b0;
    repeat (256) tick();
    chk("sweep_at_100", dut.r_sweep, 11'h100);
    RST = 1'b1;
    #1;
    chk("sweep_rst", dut.r_sweep, 0);
    chk("midsweep_busy", busy_o, 1);
    tick();
    RST = 1'b0;
    wait_init(1024);
    do_read(11'h7FF); tick();
    do_read(11'h7FE); tick();
    idle(4);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
